step_sequencer: RTL and testbench

Debug execution controller for the single-cycle RISC-V core on the Nexys A7 board. It turns debounced button presses into a one-cycle clock-enable for the core. The core then runs from the 100 MHz board clock instead of from a button-derived clock. Supported modes are single-step, free-run, counted burst-run, halt, and a PC breakpoint. It sits between the debouncer and the core, and exposes state and a retired-instruction count for the seven-segment display.

---
 rtl/step_sequencer_pkg.sv | 18 +
 rtl/step_sequencer_if.sv | 38 +++
 rtl/step_sequencer_btn_edge.sv | 30 +++
 rtl/step_sequencer.sv | 130 +++++++++++++
 tb/tb_step_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_sequencer_pkg.sv
// ============================================================================
//  Module   : step_sequencer_pkg
//  Brief    : Shared state encoding for the debug step sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package step_sequencer_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
    localparam logic [ST_W-1:0] ST_BREAK = 2'd2;

endpackage

`default_nettype wire

// File: rtl/step_sequencer_if.sv
// ============================================================================
//  Module   : step_sequencer_if
//  Brief    : Button / breakpoint / core-enable bundle between the debug
//             front end (master) and the step sequencer (slave).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface step_sequencer_if #(
    parameter int CNT_W = 16
);
    import step_sequencer_pkg::*;

    logic             btn_step;
    logic             btn_run;
    logic             btn_halt;
    logic [CNT_W-1:0] step_count;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [31:0]      pc;
    logic             core_ce;
    logic [ST_W-1:0]  state;
    logic [31:0]      retired;
    logic             bp_hit;

    modport master (
        output btn_step, btn_run, btn_halt, step_count, bp_en, bp_addr, pc,
        input  core_ce, state, retired, bp_hit
    );

    modport slave (
        input  btn_step, btn_run, btn_halt, step_count, bp_en, bp_addr, pc,
        output core_ce, state, retired, bp_hit
    );

endinterface

`default_nettype wire

// File: rtl/step_sequencer_btn_edge.sv
// ============================================================================
//  Module   : btn_edge
//  Brief    : Rising-edge detector for a debounced button level.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_edge (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_btn,
    output logic      o_rise
);

    logic btn_q;

    // Reset to 1 so a button held through reset never produces an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= i_btn;
        end
    end

    assign o_rise = i_btn & ~btn_q;

endmodule

`default_nettype wire

// File: rtl/step_sequencer.sv
// ============================================================================
//  Module   : step_sequencer
//  Brief    : Debug execution controller producing a one-clock core enable
//             for step, free-run, counted burst, halt and PC breakpoint.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_sequencer #(
    parameter int RUN_DIV = 10_000_000,
    parameter int CNT_W   = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    step_sequencer_if.slave  bus
);
    import step_sequencer_pkg::*;

    localparam int                 c_DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(RUN_DIV - 1);

    logic w_step;
    logic w_run;
    logic w_halt;
    logic w_bp_match;

    logic [ST_W-1:0]    state_q,   state_d;
    logic [c_DIV_W-1:0] div_q,     div_d;
    logic [CNT_W-1:0]   remain_q,  remain_d;
    logic               skip_q,    skip_d;
    logic               core_ce_q, core_ce_d;
    logic               bp_hit_q,  bp_hit_d;
    logic [31:0]        retired_q, retired_d;

    btn_edge u_edge_step (.clk(clk), .reset(reset), .i_btn(bus.btn_step), .o_rise(w_step));
    btn_edge u_edge_run  (.clk(clk), .reset(reset), .i_btn(bus.btn_run),  .o_rise(w_run));
    btn_edge u_edge_halt (.clk(clk), .reset(reset), .i_btn(bus.btn_halt), .o_rise(w_halt));

    assign w_bp_match = bus.bp_en && (bus.pc == bus.bp_addr);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        remain_d  = remain_q;
        skip_d    = skip_q;
        bp_hit_d  = bp_hit_q;
        core_ce_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_BREAK: begin
                // Halt while stopped is a no-op and masks lower-priority edges.
                if (!w_halt) begin
                    if (w_run) begin
                        state_d  = ST_RUN;
                        bp_hit_d = 1'b0;
                        remain_d = bus.step_count;
                        div_d    = '0;
                        skip_d   = 1'b1;
                    end else if (w_step) begin
                        core_ce_d = 1'b1;
                        state_d   = ST_IDLE;
                        bp_hit_d  = 1'b0;
                    end
                end
            end

            ST_RUN: begin
                if (w_halt) begin
                    state_d = ST_IDLE;
                end else if (w_run) begin
                    remain_d = bus.step_count;
                    div_d    = '0;
                    skip_d   = 1'b1;
                end else if (div_q == c_DIV_LAST) begin
                    div_d = '0;
                    // skip lets a resumed run step off the breakpoint it stopped on.
                    if (w_bp_match && !skip_q) begin
                        state_d  = ST_BREAK;
                        bp_hit_d = 1'b1;
                    end else begin
                        core_ce_d = 1'b1;
                        skip_d    = 1'b0;
                        if (remain_q != '0) begin
                            remain_d = remain_q - CNT_W'(1);
                        end
                        if (remain_q == CNT_W'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    div_d = div_q + c_DIV_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        retired_d = retired_q + 32'(core_ce_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            remain_q  <= '0;
            skip_q    <= 1'b0;
            core_ce_q <= 1'b0;
            bp_hit_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            remain_q  <= remain_d;
            skip_q    <= skip_d;
            core_ce_q <= core_ce_d;
            bp_hit_q  <= bp_hit_d;
            retired_q <= retired_d;
        end
    end

    assign bus.core_ce = core_ce_q;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;
    assign bus.bp_hit  = bp_hit_q;

endmodule

`default_nettype wire

// File: tb/tb_step_sequencer.sv
// ============================================================================
//  Module   : tb_step_sequencer
//  Brief    : Scoreboard testbench for step_sequencer with an event-level
//             reference model and directed plus random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_sequencer;
    import step_sequencer_pkg::*;

    localparam int RUN_DIV = 4;
    localparam int CNT_W   = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    step_sequencer_if #(.CNT_W(CNT_W)) bus ();

    step_sequencer #(.RUN_DIV(RUN_DIV), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        int          st;
        logic [31:0] pulses;
        logic        bp;
    } exp_t;

    exp_t        exp_q[$];
    int          checks  = 0;
    int          errs    = 0;
    int          cyc     = 0;
    logic [31:0] ret_off = 32'd0;
    logic [31:0] pc_mask = 32'hFFFF_FFFF;

    // Reference model state: opportunities are scheduled as absolute cycle numbers.
    int          m_st     = 0;
    logic        m_bp     = 1'b0;
    logic [31:0] m_pulses = 32'd0;
    int          m_rem    = 0;
    int          m_next   = 0;
    logic        m_skip   = 1'b0;
    logic        ps = 1'b1, pr = 1'b1, ph = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : model
        logic s, r, h, ce;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_st = 0; m_bp = 1'b0; m_pulses = 32'd0; m_rem = 0; m_skip = 1'b0;
                ps = 1'b1; pr = 1'b1; ph = 1'b1;
                exp_q.delete();
            end else begin
                cyc++;
                s  = bus.btn_step & ~ps;
                r  = bus.btn_run  & ~pr;
                h  = bus.btn_halt & ~ph;
                ps = bus.btn_step; pr = bus.btn_run; ph = bus.btn_halt;
                ce = 1'b0;
                if (m_st != 1) begin
                    if (h) begin
                        ce = 1'b0;
                    end else if (r) begin
                        m_st = 1; m_bp = 1'b0; m_skip = 1'b1;
                        m_rem = int'(bus.step_count);
                        m_next = cyc + RUN_DIV;
                    end else if (s) begin
                        ce = 1'b1; m_st = 0; m_bp = 1'b0;
                    end
                end else begin
                    if (h) begin
                        m_st = 0;
                    end else if (r) begin
                        m_skip = 1'b1;
                        m_rem = int'(bus.step_count);
                        m_next = cyc + RUN_DIV;
                    end else if (cyc == m_next) begin
                        m_next = m_next + RUN_DIV;
                        if (bus.bp_en && bus.pc == bus.bp_addr && !m_skip) begin
                            m_st = 2; m_bp = 1'b1;
                        end else begin
                            ce = 1'b1; m_skip = 1'b0;
                            if (m_rem == 1) m_st = 0;
                            if (m_rem > 0) m_rem--;
                        end
                    end
                end
                if (ce) m_pulses++;
                exp_q.push_back('{ce, m_st, m_pulses, m_bp});
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_core_ce", {31'd0, bus.core_ce}, {31'd0, e.ce});
                chk("sb_state",   {30'd0, bus.state},   e.st);
                chk("sb_retired", bus.retired,          e.pulses + ret_off);
                chk("sb_bp_hit",  {31'd0, bus.bp_hit},  {31'd0, e.bp});
            end else if (!reset && bus.core_ce) begin
                chk("sb_unexpected_ce", {31'd0, bus.core_ce}, 32'd0);
            end
        end
    end

    // The core advances pc by 4 per enable, before the next opportunity.
    task automatic tick();
        @(negedge clk);
        #1;
        if (bus.core_ce) bus.pc = (bus.pc + 32'd4) & pc_mask;
    endtask

    task automatic press_halt();
        bus.btn_halt = 1'b1;
        tick();
        bus.btn_halt = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int   e;
        int   n;
        int   pulses[$];
        logic seen;

        bus.btn_step = 1'b0; bus.btn_run = 1'b0; bus.btn_halt = 1'b0;
        bus.step_count = '0; bus.bp_en = 1'b0; bus.bp_addr = 32'd0; bus.pc = 32'd0;

        repeat (3) tick();
        chk("rst_core_ce", {31'd0, bus.core_ce}, 32'd0);
        chk("rst_state",   {30'd0, bus.state},   32'd0);
        chk("rst_retired", bus.retired,          32'd0);
        chk("rst_bp_hit",  {31'd0, bus.bp_hit},  32'd0);
        reset = 1'b0;
        repeat (6) tick();

        // Single step
        bus.btn_step = 1'b1;
        tick();
        bus.btn_step = 1'b0;
        chk("step_ce_high", {31'd0, bus.core_ce}, 32'd1);
        tick();
        chk("step_ce_one_cycle", {31'd0, bus.core_ce}, 32'd0);
        chk("step_retired", bus.retired, 32'd1);
        chk("step_state", {30'd0, bus.state}, 32'd0);

        // Counted burst of 3
        bus.step_count = 8'd3;
        bus.btn_run = 1'b1;
        e = cyc + 1;
        tick();
        bus.btn_run = 1'b0;
        repeat (18) begin
            if (bus.core_ce) pulses.push_back(cyc);
            tick();
        end
        chk("burst_npulses", pulses.size(), 32'd3);
        if (pulses.size() == 3) begin
            chk("burst_p0", pulses[0], e + 4);
            chk("burst_p1", pulses[1], e + 8);
            chk("burst_p2", pulses[2], e + 12);
        end
        chk("burst_state", {30'd0, bus.state}, 32'd0);
        chk("burst_retired", bus.retired, 32'd4);

        // Breakpoint at 0x0C in free-run from pc 0
        bus.pc = 32'd0; bus.bp_en = 1'b1; bus.bp_addr = 32'h0C; bus.step_count = '0;
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        n = 0;
        repeat (30) begin
            if (bus.core_ce) n++;
            tick();
        end
        chk("bp_npulses", n, 32'd3);
        chk("bp_state", {30'd0, bus.state}, 32'd2);
        chk("bp_hit_set", {31'd0, bus.bp_hit}, 32'd1);
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        chk("bp_resume_clear", {31'd0, bus.bp_hit}, 32'd0);
        chk("bp_resume_state", {30'd0, bus.state}, 32'd1);
        repeat (4) tick();
        chk("bp_resume_pulse", {31'd0, bus.core_ce}, 32'd1);
        press_halt();
        bus.bp_en = 1'b0;

        // Halt and run together at the terminal-count edge
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        repeat (3) tick();
        bus.btn_run = 1'b1; bus.btn_halt = 1'b1;
        tick();
        bus.btn_run = 1'b0; bus.btn_halt = 1'b0;
        chk("halt_run_ce", {31'd0, bus.core_ce}, 32'd0);
        chk("halt_run_state", {30'd0, bus.state}, 32'd0);
        tick();

        // Step and run together while idle
        bus.btn_step = 1'b1; bus.btn_run = 1'b1;
        tick();
        bus.btn_step = 1'b0; bus.btn_run = 1'b0;
        chk("step_run_state", {30'd0, bus.state}, 32'd1);
        chk("step_run_ce", {31'd0, bus.core_ce}, 32'd0);
        press_halt();

        // Reset during a pulse, then a run button held through release
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = bus.core_ce;
        end
        chk("reset_wait_pulse", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_async_ce", {31'd0, bus.core_ce}, 32'd0);
        chk("reset_async_retired", bus.retired, 32'd0);
        bus.btn_run = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("held_run_state", {30'd0, bus.state}, 32'd0);
        chk("held_run_retired", bus.retired, 32'd0);
        bus.btn_run = 1'b0;
        tick();
        bus.btn_run = 1'b1;
        tick();
        bus.btn_run = 1'b0;
        chk("repress_state", {30'd0, bus.state}, 32'd1);
        press_halt();

        // Retired counter wrap
        tick();
        force dut.retired_q = 32'hFFFF_FFFF;
        ret_off = 32'hFFFF_FFFF - m_pulses;
        #1;
        release dut.retired_q;
        bus.btn_step = 1'b1;
        tick();
        bus.btn_step = 1'b0;
        tick();
        chk("wrap_retired", bus.retired, 32'd0);

        // Random traffic against the model
        pc_mask = 32'h3F;
        bus.pc  = bus.pc & pc_mask;
        repeat (3000) begin
            tick();
            bus.btn_step   = ($urandom_range(0, 5) == 0);
            bus.btn_run    = ($urandom_range(0, 11) == 0);
            bus.btn_halt   = ($urandom_range(0, 19) == 0);
            bus.step_count = CNT_W'($urandom_range(0, 4));
            bus.bp_en      = ($urandom_range(0, 1) == 1);
            bus.bp_addr    = 32'($urandom_range(0, 15)) * 32'd4;
        end
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
